// File: rtl/uart_autobaud_ctl_pkg.sv
// ---------------------------------------------------------------------------
// uart_autobaud_ctl_pkg
// Shared definitions for the UART autobaud controller: FSM state encoding,
// the default training character and the fixed timing ratios used while
// settling and verifying a measured rate.
// ---------------------------------------------------------------------------
package uart_autobaud_ctl_pkg;

    typedef enum logic [2:0] {
        IDLE_WAIT = 3'd0,
        EDGE      = 3'd1,
        MEASURE   = 3'd2,
        SETTLE    = 3'd3,
        VERIFY    = 3'd4,
        LOCKED    = 3'd5
    } state_t;

    localparam logic [7:0] SYNC_CHAR_DEFAULT = 8'h55;

    // Consecutive high samples that qualify the line as idle.
    localparam int IDLE_HIGH_CYCLES = 16;
    // Whole bit periods skipped after the start bit before the half-period
    // step that lands mid-stop-bit of the training byte.
    localparam int SETTLE_BITS      = 8;
    // Bit periods allowed for the receiver to deliver the verify byte.
    localparam int VERIFY_BITS      = 12;

endpackage

// File: rtl/uart_baud_x16_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_x16_gen
// Programmable 16x oversample enable generator. A down-counter is loaded
// with div-1; each time it reaches zero a one-cycle baud_x16_en pulse is
// issued and the counter reloads, so pulses are div cycles apart and the
// first one arrives div cycles after the load. With en low the pulse is
// forced off and the counter holds.
//
// Ports:
//   clk_rx       in   clock
//   rst_clk_rx   in   asynchronous active-high reset
//   en           in   generator enable
//   load         in   (re)load the counter with div-1
//   div          in   DIV_W  divisor
//   baud_x16_en  out  single-cycle oversample enable
// ---------------------------------------------------------------------------
module uart_baud_x16_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk_rx,
    input  logic             rst_clk_rx,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             baud_x16_en
);

    logic [DIV_W-1:0] cnt;

    // NOTE: clocked state is assigned with <= so every register samples
    // pre-edge values; = here would make the result order-dependent.
    always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
        if (rst_clk_rx) begin
            cnt         <= '0;
            baud_x16_en <= 1'b0;
        end else if (!en) begin
            baud_x16_en <= 1'b0;
        end else if (load) begin
            cnt         <= div - DIV_W'(1);
            baud_x16_en <= 1'b0;
        end else if (cnt == '0) begin
            cnt         <= div - DIV_W'(1);
            baud_x16_en <= 1'b1;
        end else begin
            cnt         <= cnt - DIV_W'(1);
            baud_x16_en <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_autobaud_ctl.sv
// ---------------------------------------------------------------------------
// uart_autobaud_ctl
// Autobaud controller for the UART receive path. Measures the start bit of
// a sync character, derives the 16x divisor (rounded), holds the receiver
// in reset until mid-stop-bit of that character, then verifies lock on the
// next received byte and re-hunts on repeated framing errors or relock_req.
//
// Ports:
//   clk_rx         in   clock
//   rst_clk_rx     in   asynchronous active-high reset
//   rxd_clk_rx     in   synchronized RXD
//   rx_data        in   8      byte from receiver
//   rx_data_rdy    in   receiver byte strobe
//   frm_err        in   receiver framing-error strobe
//   relock_req     in   forces a re-hunt from any state
//   baud_x16_en    out  oversample enable to the receiver
//   rx_rst_clk_rx  out  synchronous hold-reset to the receiver
//   baud_div       out  DIV_W  current divisor, 0 when not valid
//   locked         out  high only in LOCKED
// ---------------------------------------------------------------------------
module uart_autobaud_ctl
    import uart_autobaud_ctl_pkg::*;
#(
    parameter int         DIV_W     = 16,
    parameter int         MIN_DIV   = 4,
    parameter logic [7:0] SYNC_CHAR = SYNC_CHAR_DEFAULT,
    parameter int         ERR_LIMIT = 4
) (
    input  logic             clk_rx,
    input  logic             rst_clk_rx,
    input  logic             rxd_clk_rx,
    input  logic [7:0]       rx_data,
    input  logic             rx_data_rdy,
    input  logic             frm_err,
    input  logic             relock_req,
    output logic             baud_x16_en,
    output logic             rx_rst_clk_rx,
    output logic [DIV_W-1:0] baud_div,
    output logic             locked
);

    localparam int MEAS_W = DIV_W + 4;
    localparam int TMO_W  = DIV_W + 8;   // holds 12 x bit_len
    localparam int ERR_W  = $clog2(ERR_LIMIT + 1);

    state_t              state, state_nxt;
    logic [3:0]          idle_cnt, idle_cnt_nxt;
    logic [MEAS_W-1:0]   meas_cnt, meas_cnt_nxt;
    logic [MEAS_W-1:0]   bit_len, bit_len_nxt;
    logic [MEAS_W-1:0]   settle_cnt, settle_cnt_nxt;
    logic [3:0]          settle_bits, settle_bits_nxt;
    logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_nxt;
    logic [ERR_W-1:0]    err_cnt, err_cnt_nxt;
    logic [DIV_W-1:0]    baud_div_nxt;
    logic                rx_rst_nxt, locked_nxt, gen_en_nxt, gen_load;

    // Rounded divisor: (meas_cnt + 8) >> 4, formed one bit wider than the
    // counter so the rounding add cannot wrap.
    logic [MEAS_W:0]     meas_round;
    logic [DIV_W-1:0]    meas_div;
    logic [MEAS_W-1:0]   settle_target;
    logic [TMO_W-1:0]    tmo_load;
    logic [ERR_W-1:0]    err_inc;

    assign meas_round    = {1'b0, meas_cnt} + (MEAS_W + 1)'(8);
    assign meas_div      = DIV_W'(meas_round >> 4);
    // Eight whole bit periods, then one half period.
    assign settle_target = (settle_bits == 4'(SETTLE_BITS)) ? (bit_len >> 1) : bit_len;
    assign tmo_load      = (TMO_W'(bit_len) << 3) + (TMO_W'(bit_len) << 2);
    assign err_inc       = err_cnt + ERR_W'(1);

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt       = state;
        idle_cnt_nxt    = idle_cnt;
        meas_cnt_nxt    = meas_cnt;
        bit_len_nxt     = bit_len;
        settle_cnt_nxt  = settle_cnt;
        settle_bits_nxt = settle_bits;
        tmo_cnt_nxt     = tmo_cnt;
        err_cnt_nxt     = err_cnt;
        baud_div_nxt    = baud_div;

        unique case (state)
            IDLE_WAIT: begin
                if (!rxd_clk_rx) begin
                    idle_cnt_nxt = '0;
                end else if (idle_cnt == 4'(IDLE_HIGH_CYCLES - 1)) begin
                    idle_cnt_nxt = '0;
                    state_nxt    = EDGE;
                end else begin
                    idle_cnt_nxt = idle_cnt + 4'd1;
                end
            end
            EDGE: begin
                if (!rxd_clk_rx) begin
                    meas_cnt_nxt = MEAS_W'(1);
                    state_nxt    = MEASURE;
                end
            end
            MEASURE: begin
                if (rxd_clk_rx) begin
                    if (meas_div < DIV_W'(MIN_DIV)) begin
                        state_nxt = IDLE_WAIT;          // glitch, not a start bit
                    end else begin
                        baud_div_nxt    = meas_div;
                        bit_len_nxt     = meas_cnt;
                        settle_cnt_nxt  = '0;
                        settle_bits_nxt = '0;
                        state_nxt       = SETTLE;
                    end
                end else if (meas_cnt == '1) begin
                    state_nxt = IDLE_WAIT;              // slower than we can measure
                end else begin
                    meas_cnt_nxt = meas_cnt + MEAS_W'(1);
                end
            end
            SETTLE: begin
                if (settle_cnt == settle_target - MEAS_W'(1)) begin
                    settle_cnt_nxt = '0;
                    if (settle_bits == 4'(SETTLE_BITS)) begin
                        tmo_cnt_nxt = tmo_load;
                        state_nxt   = VERIFY;
                    end else begin
                        settle_bits_nxt = settle_bits + 4'd1;
                    end
                end else begin
                    settle_cnt_nxt = settle_cnt + MEAS_W'(1);
                end
            end
            VERIFY: begin
                if (rx_data_rdy) begin
                    if (rx_data == SYNC_CHAR) begin
                        // A simultaneous framing error still locks but is
                        // carried into the LOCKED error count.
                        err_cnt_nxt = frm_err ? ERR_W'(1) : '0;
                        state_nxt   = LOCKED;
                    end else begin
                        state_nxt = IDLE_WAIT;
                    end
                end else if (frm_err || tmo_cnt == '0) begin
                    state_nxt = IDLE_WAIT;
                end else begin
                    tmo_cnt_nxt = tmo_cnt - TMO_W'(1);
                end
            end
            LOCKED: begin
                if (frm_err) begin
                    if (err_inc == ERR_W'(ERR_LIMIT)) state_nxt = IDLE_WAIT;
                    else                               err_cnt_nxt = err_inc;
                end else if (rx_data_rdy) begin
                    err_cnt_nxt = '0;
                end
            end
            default: state_nxt = IDLE_WAIT;
        endcase

        if (relock_req) begin
            state_nxt    = IDLE_WAIT;
            idle_cnt_nxt = '0;
        end

        // Every entry to (or stay in) IDLE_WAIT drops the divisor and counters.
        if (state_nxt == IDLE_WAIT) begin
            baud_div_nxt    = '0;
            err_cnt_nxt     = '0;
            meas_cnt_nxt    = '0;
            settle_cnt_nxt  = '0;
            settle_bits_nxt = '0;
            tmo_cnt_nxt     = '0;
        end

        gen_en_nxt = (state_nxt == VERIFY) || (state_nxt == LOCKED);
        rx_rst_nxt = !gen_en_nxt;
        locked_nxt = (state_nxt == LOCKED);
        // Generator restarts on the edge the receiver leaves reset.
        gen_load   = gen_en_nxt && rx_rst_clk_rx;
    end

    always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
        if (rst_clk_rx) begin
            state         <= IDLE_WAIT;
            idle_cnt      <= '0;
            meas_cnt      <= '0;
            bit_len       <= '0;
            settle_cnt    <= '0;
            settle_bits   <= '0;
            tmo_cnt       <= '0;
            err_cnt       <= '0;
            baud_div      <= '0;
            rx_rst_clk_rx <= 1'b1;
            locked        <= 1'b0;
        end else begin
            state         <= state_nxt;
            idle_cnt      <= idle_cnt_nxt;
            meas_cnt      <= meas_cnt_nxt;
            bit_len       <= bit_len_nxt;
            settle_cnt    <= settle_cnt_nxt;
            settle_bits   <= settle_bits_nxt;
            tmo_cnt       <= tmo_cnt_nxt;
            err_cnt       <= err_cnt_nxt;
            baud_div      <= baud_div_nxt;
            rx_rst_clk_rx <= rx_rst_nxt;
            locked        <= locked_nxt;
        end
    end

    uart_baud_x16_gen #(
        .DIV_W (DIV_W)
    ) u_gen (
        .clk_rx      (clk_rx),
        .rst_clk_rx  (rst_clk_rx),
        .en          (gen_en_nxt),
        .load        (gen_load),
        .div         (baud_div),
        .baud_x16_en (baud_x16_en)
    );

endmodule
